// File: rtl/sm3_msg_padder.sv
// SM3 message padder: packs a byte-granular word stream into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit message bit length, and
// tags each block as first/last of its message for the compression core.
module sm3_msg_padder #(
  parameter int DIN_W = 32,
  parameter int BW    = $clog2(DIN_W/8) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  input  logic             din_last,
  input  logic [BW-1:0]    din_bytes,
  output logic             din_ready,
  output logic [511:0]     blk_o,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             blk_first,
  output logic             blk_last
);

  localparam int NB = DIN_W / 8;

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_TAIL} state_t;
  // Which extra length-only block is owed after the current block.
  typedef enum logic [1:0] {TK_NONE, TK_ZERO, TK_MARK} tail_t;

  state_t        state_q, state_d;
  tail_t         tail_q, tail_d;
  logic [511:0]  buf_q, buf_d;
  logic [6:0]    pos_q, pos_d;
  logic [60:0]   cnt_q, cnt_d;
  logic          first_pend_q, first_pend_d;
  logic          first_q, first_d;
  logic          last_q, last_d;

  logic [6:0]       nb;
  logic [6:0]       p;
  logic [DIN_W-1:0] word_m;
  logic [511:0]     placed;
  logic [511:0]     marker;
  logic [60:0]      cnt_sum;

  assign din_ready = (state_q == S_FILL);
  assign blk_valid = (state_q == S_EMIT);
  assign blk_o     = buf_q;
  assign blk_first = first_q;
  assign blk_last  = last_q;

  // Word alignment: clamp the byte count, mask unused bytes, place at pos.
  always_comb begin
    nb = 7'(NB);
    if (din_last && (7'(din_bytes) < 7'(NB))) nb = 7'(din_bytes);
    word_m = din;
    for (int k = 0; k < NB; k++) begin
      if (k >= int'(nb)) word_m[DIN_W-1-8*k -: 8] = 8'h00;
    end
    placed  = {word_m, {(512-DIN_W){1'b0}}} >> {pos_q, 3'b000};
    p       = pos_q + nb;
    marker  = {8'h80, 504'b0} >> {p, 3'b000};
    cnt_sum = cnt_q + 61'(nb);
  end

  // Next-state and datapath update for FILL / EMIT / TAIL.
  always_comb begin
    state_d      = state_q;
    tail_d       = tail_q;
    buf_d        = buf_q;
    pos_d        = pos_q;
    cnt_d        = cnt_q;
    first_pend_d = first_pend_q;
    first_d      = first_q;
    last_d       = last_q;
    case (state_q)
      S_FILL: begin
        if (din_valid) begin
          buf_d = buf_q | placed;
          cnt_d = cnt_sum;
          pos_d = p;
          if (!din_last) begin
            if (p == 7'd64) begin
              state_d = S_EMIT;
              last_d  = 1'b0;
              first_d = first_pend_q;
              tail_d  = TK_NONE;
            end
          end else begin
            state_d = S_EMIT;
            first_d = first_pend_q;
            if (p <= 7'd55) begin
              buf_d  = buf_q | placed | marker | {448'b0, cnt_sum, 3'b000};
              last_d = 1'b1;
              tail_d = TK_NONE;
            end else if (p <= 7'd63) begin
              buf_d  = buf_q | placed | marker;
              last_d = 1'b0;
              tail_d = TK_ZERO;
            end else begin
              last_d = 1'b0;
              tail_d = TK_MARK;
            end
          end
        end
      end
      S_EMIT: begin
        if (blk_ready) begin
          first_pend_d = last_q;
          if (last_q) cnt_d = '0;
          if (tail_q != TK_NONE) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_FILL;
            buf_d   = '0;
            pos_d   = '0;
          end
        end
      end
      S_TAIL: begin
        buf_d   = {(tail_q == TK_MARK) ? 8'h80 : 8'h00, 440'b0, cnt_q, 3'b000};
        tail_d  = TK_NONE;
        pos_d   = '0;
        last_d  = 1'b1;
        first_d = first_pend_q;
        state_d = S_EMIT;
      end
      default: state_d = S_FILL;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FILL;
      tail_q       <= TK_NONE;
      buf_q        <= '0;
      pos_q        <= '0;
      cnt_q        <= '0;
      first_pend_q <= 1'b1;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tail_q       <= tail_d;
      buf_q        <= buf_d;
      pos_q        <= pos_d;
      cnt_q        <= cnt_d;
      first_pend_q <= first_pend_d;
      first_q      <= first_d;
      last_q       <= last_d;
    end
  end

endmodule

// File: doc/sm3_msg_padder.md
# sm3_msg_padder

Parametrised SM3 message padder and block former in front of the SM3 compression core. Accepts a byte-granular message as a stream of DIN_W-bit big-endian words. Appends the 0x80 marker, zero fill and 64-bit bit-length per GB/T 32905. Emits complete 512-bit blocks with first/last flags, so hosts no longer pre-pad or split messages themselves. Those flags select the core's "new message" vs "continue" command.

## Interface
- DIN_W, 32: input word width; 32 or 64 (multiple of 8, divides 512).
- BW, $clog2(DIN_W/8)+1: width of din_bytes (derived; do not override).
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  DIN_W  message word, first byte in MSBs.
- din_valid  in  1  din/din_last/din_bytes valid.
- din_last  in  1  word is final word of message.
- din_bytes  in  BW  valid bytes in a last word, 0..DIN_W/8; ignored when din_last=0; values above DIN_W/8 treated as DIN_W/8.
- din_ready  out  1  padder accepts a word this cycle.
- blk_o  out  512  formed block, message byte 0 in bits 511:504.
- blk_valid  out  1  blk_o valid.
- blk_ready  in  1  downstream core takes block.
- blk_first  out  1  block is first of its message.
- blk_last  out  1  block is final (carries length).

## Operation
- States: FILL, EMIT, TAIL.
- Registers:
  - 512-bit buffer.
  - byte position pos, 0..64.
  - 61-bit message byte counter, bit length = count<<3, wraps mod 2^64.
  - first_pending flag, set at reset and after each final block.
  - tail_kind.
- FILL: din_ready=1.
  - Word handshake: din_valid & din_ready.
  - Non-last word: copied into buffer at pos; pos += DIN_W/8; counter += DIN_W/8.
  - When pos reaches 64 → EMIT with blk_last=0.
  - Last word: only din_bytes bytes copied, remaining bytes of the word masked to 0; counter += din_bytes; p = pos + din_bytes.
    - p ≤ 55: 0x80 at byte p, zeros to byte 55, length in bytes 56..63 → EMIT, blk_last=1.
    - 56 ≤ p ≤ 63: 0x80 at byte p, zeros to end → EMIT, blk_last=0, tail_kind=ZERO.
    - p = 64: block emitted as pure data → EMIT, blk_last=0, tail_kind=MARK.
- EMIT: blk_valid=1; blk_o, blk_first, blk_last held stable until blk_ready.
  - On handshake with a tail pending → TAIL.
  - Otherwise → FILL with buffer cleared and pos=0.
  - If blk_last was 1: counter cleared, first_pending set.
- TAIL (one cycle):
  - Builds the final block: 0x80 in byte 0 if tail_kind=MARK, else zero; zeros to byte 55; length in bytes 56..63.
  - Then → EMIT with blk_last=1.
- blk_first = first_pending latched at the transition into EMIT; first_pending cleared on that block's handshake.
- Empty message: last word with din_bytes=0 at pos=0 → single block 0x80, zeros, length 0.
- din_valid is ignored outside FILL. No word is lost: the source holds it while din_ready=0.

## Timing
- Reset, sampled at clk edge:
  - state=FILL, pos=0, counter=0, buffer=0, first_pending=1.
  - blk_o=0, blk_valid=0, blk_first=0, blk_last=0.
  - din_ready=1 in the first cycle after reset deasserts.
- Reset mid-message or mid-EMIT discards all partial data; blk_valid=0 from the next cycle.
- Block-completing word accepted at edge t → blk_valid=1 in cycle t+1.
- EMIT handshake at edge t:
  - → FILL: din_ready=1 in cycle t+1.
  - → TAIL: tail block valid in cycle t+2.
- Max throughput, DIN_W=32: 16 accept cycles + 1 EMIT cycle per block with blk_ready held high.
- Single-block message: 1 EMIT cycle. Two-block tail: EMIT, TAIL, EMIT.
- blk_valid, once asserted, never drops before the handshake except by reset.
- din_ready is a function of state only. There is no combinational path from blk_ready to din_ready.

## Test plan
- DIN_W=32, one word 0x61626300 with din_last=1, din_bytes=3 ("abc"):
  - one block 0x61626380, then zeros, then length 0x…0018.
  - blk_first=blk_last=1; blk_valid one cycle after the accept.
- Empty message (din_last=1, din_bytes=0):
  - block 0x80000000…0, length 0, first=last=1.
- 55-byte message (13 full words plus last word with din_bytes=3):
  - single block, 0x80 at byte 55, length 0x1B8.
- 56-byte message (14 full words):
  - block 1 = data, 0x80, zeros, first=1, last=0.
  - TAIL block = zeros plus length 0x1C0, first=0, last=1.
- 64-byte message (16 full words):
  - data block, last=0.
  - then 0x80…0 block with length 0x200, last=1.
  - Back-to-back second message: its block has blk_first=1, counter restarted.
- blk_ready held low 5 cycles during EMIT:
  - blk_o and flags stable, din_ready=0.
- reset pulsed after 7 words:
  - next "abc" message yields the exact first-scenario block.
- Repeat the "abc" and 56-byte cases with DIN_W=64.
